perip_bridge: RTL and testbench
===============================

PERIP_BRIDGE -- requirements
Module: perip_bridge

Interface
REQ-001 SHALL have parameter CYCLES_PER_MS, default 50000, giving cpu_clk cycles per millisecond tick of the counter peripheral.
REQ-002 SHALL have parameter SCAN_CYCLES, default 50000, giving cpu_clk cycles each seven-segment digit is displayed.
REQ-003 SHALL have port cpu_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port cpu_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port perip_addr  input  32  CPU data-access byte address.
REQ-006 SHALL have port perip_wen  input  1  CPU write strobe.
REQ-007 SHALL have port perip_mask  input  2  access size: 00 byte, 01 half, 10 word.
REQ-008 SHALL have port perip_wdata  input  32  CPU write data.
REQ-009 SHALL have port perip_rdata  output  32  read data returned to the CPU.
REQ-010 SHALL have ports dram_addr (output, 32), dram_wen (output, 1), dram_mask (output, 2), dram_wdata (output, 32), dram_rdata (input, 32) forming the data-RAM port.
REQ-011 SHALL have ports sw (input, 32) for switches, key (input, 8) for buttons, and led (output, 32) for LEDs.
REQ-012 SHALL have ports seg_en (output, 8) and seg_out (output, 8): active-low digit enables and segments {dp,g,f,e,d,c,b,a}.

Function
REQ-013 SHALL decode the address map as follows:
- DRAM: 0x8010_0000-0x8013_FFFF.
- SW: 0x8020_0000 (read-only).
- KEY: 0x8020_0010 (read-only, zero-extended).
- SEG: 0x8020_0020 (read/write).
- LED: 0x8020_0040 (read/write).
- CNT: 0x8020_0050 (read/write).
REQ-014 SHALL drive dram_addr=perip_addr, dram_mask=perip_mask and dram_wdata=perip_wdata unconditionally, and dram_wen=perip_wen only on a DRAM hit.
REQ-015 SHALL make perip_rdata combinational, with zero-cycle latency: dram_rdata on a DRAM hit, the register value on a peripheral hit, 0 on an unmapped address.
REQ-016 SHALL update a peripheral register on the rising edge after perip_wen=1 with a hit and perip_mask=10; writes with any other mask, and writes to SW, KEY or unmapped addresses, SHALL be ignored.
REQ-017 SHALL pass sw and key through a two-flop synchronizer, so a read reflects the pin value after exactly 2 cycles.
REQ-018 SHALL drive led continuously from the LED register.
REQ-019 SHALL implement the counter as a two-state FSM, IDLE and RUN, plus a prescaler (0..CYCLES_PER_MS-1) and a 32-bit ms_count.
REQ-020 SHALL, on a CNT write of 0x8000_0000: clear ms_count and the prescaler and enter RUN, from either state.
REQ-021 SHALL, on a CNT write of 0xFFFF_FFFF: enter IDLE and freeze ms_count; any other CNT write value SHALL be ignored.
REQ-022 SHALL, in RUN, increment the prescaler each cycle; when it reaches CYCLES_PER_MS-1 it wraps to 0 and ms_count increments, wrapping from 0xFFFF_FFFF to 0.
REQ-023 SHALL make a CNT read return ms_count in either state.
REQ-024 SHALL give a start write priority over the same-cycle increment: ms_count is 0 on the next cycle.
REQ-025 SHALL scan the seven-segment display as follows:
- a scan counter (0..SCAN_CYCLES-1) advances a 3-bit digit index 0..7, wrapping 7 to 0.
- seg_en has only bit[index] low.
- seg_out is the active-low hex glyph of SEG[4*index+3:4*index], with dp off (bit7=1).
REQ-026 SHALL decode hex glyphs as 0 -> 0xC0, 1 -> 0xF9, 8 -> 0x80, F -> 0x8E (standard common-anode table for all 16 values).

Reset
REQ-027 SHALL, while cpu_rst=0, immediately and asynchronously clear:
- LED, SEG, ms_count, prescaler, scan counter, digit index and the synchronizers.
- FSM state to IDLE.
REQ-028 SHALL hold seg_en=0xFE and seg_out=0xC0 during reset.
REQ-029 SHALL, on a reset assertion mid-count, discard the count; after release, CNT reads 0 and the FSM stays IDLE until a start write.

Verification
REQ-030 Reset: assert cpu_rst=0 mid-cycle -> led=0, seg_en=0xFE, seg_out=0xC0, CNT read=0, without waiting for a clock edge.
REQ-031 LED: word-write 0x8020_0040=0xA5A5_0F0F -> led=0xA5A5_0F0F next cycle and readback matches; a byte-mask write of 0x1 -> led unchanged.
REQ-032 Counter (CYCLES_PER_MS=4): write CNT=0x8000_0000, wait 12 cycles -> read 3; write 0xFFFF_FFFF -> reads stay 3 for 20 cycles; restart -> read 0 next cycle.
REQ-033 Counter wrap: force ms_count=0xFFFF_FFFF in RUN, wait 4 cycles -> read 0.
REQ-034 DRAM/unmapped: read 0x8010_0004 with dram_rdata=0x1234_5678 -> perip_rdata=0x1234_5678 same cycle; write 0x8020_0000 -> dram_wen=0, no state change; read 0x9000_0000 -> 0.
REQ-035 Scan (SCAN_CYCLES=2, SEG=0x0000_0081): seg_en steps 0xFE -> 0xFD every 2 cycles; digit0 seg_out=0xF9, digit1 seg_out=0x80; after digit7 returns to 0xFE.

Source files
------------

// File: rtl/perip_bridge.sv
// perip_bridge: CPU data-bus bridge splitting accesses between data RAM and memory-mapped peripherals.
// Ports:
//   cpu_clk, cpu_rst            clock, asynchronous active-low reset
//   perip_addr/wen/mask/wdata   CPU data access in; perip_rdata combinational read data out
//   dram_*                      data-RAM port (address/data/mask pass through, wen gated by DRAM hit)
//   sw, key                     switch and button pins (synchronized before readback)
//   led                         LED register output
//   seg_en, seg_out             active-low multiplexed seven-segment digit enables and segments
// Map: DRAM 0x8010_0000-0x8013_FFFF, SW 0x8020_0000, KEY 0x8020_0010, SEG 0x8020_0020,
//      LED 0x8020_0040, CNT 0x8020_0050 (millisecond counter: write 0x8000_0000 start, 0xFFFF_FFFF stop).
module perip_bridge #(
    parameter int CYCLES_PER_MS = 50000,
    parameter int SCAN_CYCLES   = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] perip_addr,
    input  logic        perip_wen,
    input  logic [1:0]  perip_mask,
    input  logic [31:0] perip_wdata,
    output logic [31:0] perip_rdata,
    output logic [31:0] dram_addr,
    output logic        dram_wen,
    output logic [1:0]  dram_mask,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [31:0] sw,
    input  logic [7:0]  key,
    output logic [31:0] led,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);
    localparam logic [31:0] SW_ADDR  = 32'h8020_0000;
    localparam logic [31:0] KEY_ADDR = 32'h8020_0010;
    localparam logic [31:0] SEG_ADDR = 32'h8020_0020;
    localparam logic [31:0] LED_ADDR = 32'h8020_0040;
    localparam logic [31:0] CNT_ADDR = 32'h8020_0050;
    localparam logic [31:0] CNT_START = 32'h8000_0000;
    localparam logic [31:0] CNT_STOP  = 32'hFFFF_FFFF;
    localparam int PW = CYCLES_PER_MS > 1 ? $clog2(CYCLES_PER_MS) : 1;
    localparam int SW_W = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(CYCLES_PER_MS - 1);
    localparam logic [SW_W-1:0] SCAN_MAX = SW_W'(SCAN_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic          dram_hit, sw_hit, key_hit, seg_hit, led_hit, cnt_hit, wr_ok;
    logic          cnt_start, cnt_stop, ms_tick, scan_wrap;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   ms_q, ms_d;
    logic [31:0]   led_q, led_d, seg_q, seg_d;
    logic [31:0]   sw_s1_q, sw_s2_q;
    logic [7:0]    key_s1_q, key_s2_q;
    logic [SW_W-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;

    // The DRAM window is 256 KiB aligned, so the upper 14 address bits identify it.
    assign dram_hit = perip_addr[31:18] == 14'h2004;
    assign sw_hit   = perip_addr == SW_ADDR;
    assign key_hit  = perip_addr == KEY_ADDR;
    assign seg_hit  = perip_addr == SEG_ADDR;
    assign led_hit  = perip_addr == LED_ADDR;
    assign cnt_hit  = perip_addr == CNT_ADDR;
    // Peripheral registers only accept full-word writes.
    assign wr_ok    = perip_wen && perip_mask == 2'b10;

    assign dram_addr  = perip_addr;
    assign dram_mask  = perip_mask;
    assign dram_wdata = perip_wdata;
    assign dram_wen   = perip_wen && dram_hit;

    assign perip_rdata = dram_hit ? dram_rdata :
                         sw_hit   ? sw_s2_q :
                         key_hit  ? {24'b0, key_s2_q} :
                         seg_hit  ? seg_q :
                         led_hit  ? led_q :
                         cnt_hit  ? ms_q : 32'b0;

    assign led_d = (wr_ok && led_hit) ? perip_wdata : led_q;
    assign seg_d = (wr_ok && seg_hit) ? perip_wdata : seg_q;
    assign led   = led_q;

    assign cnt_start = wr_ok && cnt_hit && perip_wdata == CNT_START;
    assign cnt_stop  = wr_ok && cnt_hit && perip_wdata == CNT_STOP;
    assign ms_tick   = pre_q == PRE_MAX;

    // Start wins over everything, including an increment due in the same cycle.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        if (cnt_start) begin
            state_d = RUN;
            pre_d   = '0;
            ms_d    = '0;
        end else if (cnt_stop) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            pre_d = ms_tick ? '0 : pre_q + 1'b1;
            ms_d  = ms_tick ? ms_q + 32'd1 : ms_q;
        end
    end

    assign scan_wrap = scan_q == SCAN_MAX;
    assign scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    assign idx_d     = scan_wrap ? idx_q + 3'd1 : idx_q;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    // Reset clears SEG and the index, so the display shows digit 0 as "0" during reset.
    assign seg_en  = ~(8'd1 << idx_q);
    assign seg_out = glyph(seg_q[{idx_q, 2'b00} +: 4]);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            ms_q     <= '0;
            led_q    <= '0;
            seg_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '0;
            key_s2_q <= '0;
            scan_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
        end
    end
endmodule

// File: tb/tb_perip_bridge.sv
// tb_perip_bridge: randomized self-checking bench for perip_bridge against a cycle-count based model.
module tb_perip_bridge;
    localparam int CPM = 4;
    localparam int SCN = 2;
    localparam logic [31:0] SW_A = 32'h8020_0000, KEY_A = 32'h8020_0010, SEG_A = 32'h8020_0020;
    localparam logic [31:0] LED_A = 32'h8020_0040, CNT_A = 32'h8020_0050;
    localparam logic [31:0] START = 32'h8000_0000, STOP = 32'hFFFF_FFFF;

    logic        clk = 0, rst_n = 0;
    logic [31:0] perip_addr = 0, perip_wdata = 0, dram_rdata = 0, sw = 0;
    logic        perip_wen = 0;
    logic [1:0]  perip_mask = 0;
    logic [7:0]  key = 0;
    logic [31:0] perip_rdata, dram_addr, dram_wdata, led;
    logic        dram_wen;
    logic [1:0]  dram_mask;
    logic [7:0]  seg_en, seg_out;

    perip_bridge #(.CYCLES_PER_MS(CPM), .SCAN_CYCLES(SCN)) dut (
        .cpu_clk(clk), .cpu_rst(rst_n),
        .perip_addr(perip_addr), .perip_wen(perip_wen), .perip_mask(perip_mask),
        .perip_wdata(perip_wdata), .perip_rdata(perip_rdata),
        .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_mask(dram_mask),
        .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
        .sw(sw), .key(key), .led(led), .seg_en(seg_en), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0;
    int cyc = 0;
    logic [31:0] swq[$];
    logic [7:0]  keyq[$];
    logic [31:0] led_m = 0, seg_m = 0, base_m = 0, frz_m = 0;
    bit          run_m = 0;
    int          start_c = 0;
    logic [7:0]  glyph_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Cycle count since reset release plus the pin history seen at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            swq.delete(); keyq.delete();
            swq.push_back(0); swq.push_back(0);
            keyq.push_back(0); keyq.push_back(0);
        end else begin
            cyc++;
            swq.push_back(sw);
            keyq.push_back(key);
            if (swq.size() > 4) begin swq.pop_front(); keyq.pop_front(); end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_dram(input logic [31:0] a);
        return a >= 32'h8010_0000 && a <= 32'h8013_FFFF;
    endfunction

    function automatic logic [31:0] cnt_exp();
        return run_m ? base_m + 32'((cyc - start_c) / CPM) : frz_m;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [31:0] dr);
        if (is_dram(a)) return dr;
        if (a == SW_A)  return swq[$-1];
        if (a == KEY_A) return {24'b0, keyq[$-1]};
        if (a == SEG_A) return seg_m;
        if (a == LED_A) return led_m;
        if (a == CNT_A) return cnt_exp();
        return 0;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        perip_addr = a; perip_wdata = d; perip_mask = m; perip_wen = 1;
        #1;
        check("dram_wen", {31'b0, dram_wen}, {31'b0, is_dram(a)});
        check("dram_addr", dram_addr, a);
        check("dram_wdata", dram_wdata, d);
        check("dram_mask", {30'b0, dram_mask}, {30'b0, m});
        step();
        perip_wen = 0;
        if (m == 2'b10) begin
            if (a == LED_A) led_m = d;
            if (a == SEG_A) seg_m = d;
            if (a == CNT_A && d == START) begin
                run_m = 1; base_m = 0; start_c = cyc;
            end else if (a == CNT_A && d == STOP) begin
                if (run_m) frz_m = base_m + 32'((cyc - 1 - start_c) / CPM);
                run_m = 0;
            end
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] dr, input string tag);
        perip_addr = a; dram_rdata = dr; perip_wen = 0;
        #1;
        check(tag, perip_rdata, exp_rd(a, dr));
    endtask

    task automatic chk_out();
        int idx;
        idx = (cyc / SCN) % 8;
        check("led", led, led_m);
        check("seg_en", {24'b0, seg_en}, {24'b0, ~(8'h01 << idx)});
        check("seg_out", {24'b0, seg_out}, {24'b0, glyph_t[seg_m[idx*4 +: 4]]});
    endtask

    task automatic do_reset();
        #3 rst_n = 0;
        led_m = 0; seg_m = 0; run_m = 0; frz_m = 0; base_m = 0;
        #1;
        check("rst_led", led, 0);
        check("rst_seg_en", {24'b0, seg_en}, 32'hFE);
        check("rst_seg_out", {24'b0, seg_out}, 32'hC0);
        bus_rd(CNT_A, 0, "rst_cnt");
        check("rst_cnt_const", perip_rdata, 0);
        step();
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d, dr;
        logic [1:0]  m;
        repeat (2) step();
        do_reset();
        // LED word write, readback, and ignored sub-word masks
        bus_wr(LED_A, 32'hA5A5_0F0F, 2'b10);
        check("led_word", led, 32'hA5A5_0F0F);
        bus_rd(LED_A, 0, "led_rd");
        bus_wr(LED_A, 32'h1, 2'b00);
        check("led_byte_ign", led, 32'hA5A5_0F0F);
        bus_wr(LED_A, 32'h1, 2'b01);
        bus_wr(LED_A, 32'h1, 2'b11);
        chk_out();
        // DRAM pass-through, read-only and unmapped addresses
        bus_rd(32'h8010_0004, 32'h1234_5678, "dram_rd");
        check("dram_rd_const", perip_rdata, 32'h1234_5678);
        bus_rd(32'h8013_FFFC, 32'hCAFE_F00D, "dram_top");
        bus_rd(32'h8014_0000, 32'hCAFE_F00D, "dram_past");
        bus_rd(32'h800F_FFFC, 32'hCAFE_F00D, "dram_below");
        sw = 32'h5A5A_1234; key = 8'h3C;
        bus_wr(SW_A, 32'hDEAD_BEEF, 2'b10);
        bus_wr(KEY_A, 32'hDEAD_BEEF, 2'b10);
        bus_rd(SW_A, 0, "sw_rd");
        check("sw_const", perip_rdata, 32'h5A5A_1234);
        bus_rd(KEY_A, 0, "key_rd");
        bus_wr(32'h8010_0008, 32'h0BAD_CAFE, 2'b10);
        bus_rd(32'h9000_0000, 32'h1234_5678, "unmapped");
        check("unmapped_const", perip_rdata, 0);
        chk_out();
        // Counter: 12 cycles -> 3, freeze on stop, restart reads 0
        bus_wr(CNT_A, START, 2'b10);
        repeat (12) step();
        bus_rd(CNT_A, 0, "cnt12");
        check("cnt12_const", perip_rdata, 3);
        bus_wr(CNT_A, STOP, 2'b10);
        for (int i = 0; i < 20; i++) begin
            step();
            bus_rd(CNT_A, 0, "cnt_frozen");
        end
        check("cnt_frozen_const", perip_rdata, 3);
        bus_wr(CNT_A, START, 2'b10);
        bus_rd(CNT_A, 0, "cnt_restart");
        check("cnt_restart_const", perip_rdata, 0);
        bus_wr(CNT_A, 32'h1234_5678, 2'b10);
        repeat (5) step();
        bus_rd(CNT_A, 0, "cnt_other_ign");
        // Start lands on the same edge as a due increment
        bus_wr(CNT_A, START, 2'b10);
        repeat (3) step();
        bus_wr(CNT_A, START, 2'b10);
        bus_rd(CNT_A, 0, "cnt_prio");
        check("cnt_prio_const", perip_rdata, 0);
        // Wrap from 0xFFFF_FFFF
        force dut.ms_q = 32'hFFFF_FFFF;
        #1 release dut.ms_q;
        base_m = 32'hFFFF_FFFF;
        repeat (3) step();
        bus_rd(CNT_A, 0, "cnt_pre_wrap");
        step();
        bus_rd(CNT_A, 0, "cnt_wrap");
        check("cnt_wrap_const", perip_rdata, 0);
        // Scan through all digits
        bus_wr(SEG_A, 32'h0000_0081, 2'b10);
        for (int i = 0; i < 20; i++) begin
            chk_out();
            step();
        end
        // Reset mid-count discards the count and leaves the counter idle
        bus_wr(CNT_A, START, 2'b10);
        repeat (9) step();
        do_reset();
        repeat (10) step();
        bus_rd(CNT_A, 0, "cnt_after_rst");
        check("cnt_after_rst_const", perip_rdata, 0);
        chk_out();
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sw = $urandom; key = 8'($urandom);
            case ($urandom_range(0, 7))
                0: a = 32'h8010_0000 + {14'b0, 16'($urandom), 2'b00};
                1: a = SW_A;
                2: a = KEY_A;
                3: a = SEG_A;
                4: a = LED_A;
                5: a = CNT_A;
                6: a = 32'h8020_0000 + 32'($urandom_range(0, 31) * 4);
                default: a = $urandom;
            endcase
            m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            case ($urandom_range(0, 3))
                0: d = START;
                1: d = STOP;
                default: d = $urandom;
            endcase
            dr = $urandom;
            if ($urandom_range(0, 1) == 0) bus_wr(a, d, m);
            else begin
                bus_rd(a, dr, "rand_rd");
                bus_rd(CNT_A, dr, "rand_cnt");
                step();
            end
            chk_out();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
